// File: rtl/isa_pkg.sv
// ISA constants, FSM state encoding and field-packing helpers for the program loader.
// Opcode/func values mirror the pipeline CPU's decoder tables.
// Shared by the encoder, the loader top and anything that needs the instruction format.
package isa_pkg;

  // Mnemonic codes as presented on the command interface
  typedef enum logic [3:0] {
    MN_ADD     = 4'd0,
    MN_AND     = 4'd1,
    MN_OR      = 4'd2,
    MN_XOR     = 4'd3,
    MN_SRL     = 4'd4,
    MN_SLL     = 4'd5,
    MN_ADDI    = 4'd6,
    MN_ANDI    = 4'd7,
    MN_ORI     = 4'd8,
    MN_XORI    = 4'd9,
    MN_LW      = 4'd10,
    MN_SW      = 4'd11,
    MN_BEQ     = 4'd12,
    MN_BNE     = 4'd13,
    MN_J       = 4'd14,
    MN_ILLEGAL = 4'd15
  } mnem_e;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_LOGIC = 6'b000001;
  localparam logic [5:0] OP_SHIFT = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001010;
  localparam logic [5:0] OP_XORI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b001111;
  localparam logic [5:0] OP_BNE   = 6'b010000;
  localparam logic [5:0] OP_J     = 6'b010010;

  // Function codes for the R-type groups, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b000001;
  localparam logic [5:0] FN_OR  = 6'b000010;
  localparam logic [5:0] FN_XOR = 6'b000100;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SLL = 6'b000011;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // R-type layout: op | rs | rt | rd | sa | func
  function automatic logic [31:0] pack_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sa, input logic [5:0] fn);
    return {op, rs, rt, rd, sa, fn};
  endfunction

  // I-type layout: op | rs | rt | imm
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // J-type layout: op | target
  function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational mnemonic-plus-fields to 32-bit instruction encoder.
// Zero latency; purely combinational, no flow control.
// Fields an instruction does not use are forced to zero; code 15 flags illegal.
module instr_encode (
  input  logic [3:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  sa_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);
  import isa_pkg::*;

  // Select the instruction format and opcode/func for the mnemonic
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (mnem_e'(mnem_i))
      MN_ADD:  word_o = pack_r(OP_ADD,   rs_i, rt_i, rd_i, sa_i, FN_ADD);
      MN_AND:  word_o = pack_r(OP_LOGIC, rs_i, rt_i, rd_i, sa_i, FN_AND);
      MN_OR:   word_o = pack_r(OP_LOGIC, rs_i, rt_i, rd_i, sa_i, FN_OR);
      MN_XOR:  word_o = pack_r(OP_LOGIC, rs_i, rt_i, rd_i, sa_i, FN_XOR);
      // Shifts take their operand from rt; the rs slot is always emitted as zero
      MN_SRL:  word_o = pack_r(OP_SHIFT, 5'd0, rt_i, rd_i, sa_i, FN_SRL);
      MN_SLL:  word_o = pack_r(OP_SHIFT, 5'd0, rt_i, rd_i, sa_i, FN_SLL);
      MN_ADDI: word_o = pack_i(OP_ADDI,  rs_i, rt_i, imm_i);
      MN_ANDI: word_o = pack_i(OP_ANDI,  rs_i, rt_i, imm_i);
      MN_ORI:  word_o = pack_i(OP_ORI,   rs_i, rt_i, imm_i);
      MN_XORI: word_o = pack_i(OP_XORI,  rs_i, rt_i, imm_i);
      MN_LW:   word_o = pack_i(OP_LW,    rs_i, rt_i, imm_i);
      MN_SW:   word_o = pack_i(OP_SW,    rs_i, rt_i, imm_i);
      MN_BEQ:  word_o = pack_i(OP_BEQ,   rs_i, rt_i, imm_i);
      MN_BNE:  word_o = pack_i(OP_BNE,   rs_i, rt_i, imm_i);
      MN_J:    word_o = pack_j(OP_J,     target_i);
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic commands and writes them sequentially into instruction memory.
// Latency: one cycle from command handshake to IMEM write; one instruction per cycle.
// Backpressure: cmd_ready is high only in RUN while legal instructions remain to be written.
module instr_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  prog_len,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_mnem,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_sa,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import isa_pkg::*;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                hs;
  logic                last_hs;

  instr_encode u_instr_encode (
    .mnem_i   (cmd_mnem),
    .rs_i     (cmd_rs),
    .rt_i     (cmd_rt),
    .rd_i     (cmd_rd),
    .sa_i     (cmd_sa),
    .imm_i    (cmd_imm),
    .target_i (cmd_target),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  assign cmd_ready = (state_q == ST_RUN) && (remaining_q != '0);
  assign hs        = cmd_valid & cmd_ready;
  assign last_hs   = hs && enc_legal && (remaining_q == CNT_W'(1));

  // Session sequencing: IDLE -> RUN -> DRAIN -> FIN -> IDLE, or IDLE -> FIN for an empty program
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (prog_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_hs) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address/count bookkeeping, write-port staging, done pulse and sticky error
  always_comb begin
    addr_ptr_d  = addr_ptr_q;
    remaining_d = remaining_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = (state_q == ST_FIN);
    err_d       = err_q;

    if ((state_q == ST_IDLE) && start) begin
      addr_ptr_d  = base_addr;
      remaining_d = prog_len;
      err_d       = 1'b0;
    end

    if (hs) begin
      if (enc_legal) begin
        we_d        = 1'b1;
        waddr_d     = addr_ptr_q;
        wdata_d     = enc_word;
        addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
        remaining_d = remaining_q - CNT_W'(1);
      end else begin
        // Illegal commands are swallowed: nothing written, count untouched
        err_d = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_ptr_q  <= '0;
      remaining_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_ptr_q  <= addr_ptr_d;
      remaining_q <= remaining_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A reset arriving while a write is staged kills the strobe in that same cycle
  assign imem_we    = we_q & ~rst;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised and directed bench for instr_encoder_loader with a session-level reference model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, cmd_valid;
  logic [7:0]  base_addr;
  logic [8:0]  prog_len;
  logic        cmd_ready;
  logic [3:0]  cmd_mnem;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd, cmd_sa;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .prog_len(prog_len),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mnem(cmd_mnem),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_sa(cmd_sa),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference encoding straight from the ISA tables (index = mnemonic code)
  logic [5:0] op_tab [0:14] = '{6'h00, 6'h01, 6'h01, 6'h01, 6'h02, 6'h02, 6'h05, 6'h09,
                                6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h12};
  logic [5:0] fn_tab [0:5]  = '{6'h01, 6'h01, 6'h02, 6'h04, 6'h02, 6'h03};

  function automatic logic [31:0] ref_encode(input logic [3:0] m, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [4:0] sa, input logic [15:0] imm,
                                             input logic [25:0] tgt);
    if (m < 4)       return {op_tab[m], rs, rt, rd, sa, fn_tab[m]};
    else if (m < 6)  return {op_tab[m], 5'd0, rt, rd, sa, fn_tab[m]};
    else if (m < 14) return {op_tab[m], rs, rt, imm};
    else             return {op_tab[m], tgt};
  endfunction

  // Session model: accepting flag, remaining count, pointer, countdown to the done pulse
  bit          m_acc, m_err, m_idle, m_last, model_ok;
  int          m_rem, m_done_in;
  logic [7:0]  m_ptr;
  logic        e_we, e_ready, e_busy, e_done, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;

  initial model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_acc = 0; m_err = 0; m_rem = 0; m_done_in = 0; m_ptr = 8'd0;
      e_we = 0; e_ready = 0; e_busy = 0; e_done = 0; e_err = 0;
      e_addr = 8'd0; e_wdata = 32'd0;
      model_ok = 1'b1;
    end else begin
      m_idle = !m_acc && (m_done_in == 0);
      m_last = 0;
      e_we   = 0;
      e_done = (m_done_in == 1);
      if (m_done_in > 0) m_done_in = m_done_in - 1;
      if (m_acc && cmd_valid) begin
        if (cmd_mnem == 4'd15) begin
          m_err = 1;
        end else begin
          e_we    = 1;
          e_addr  = m_ptr;
          e_wdata = ref_encode(cmd_mnem, cmd_rs, cmd_rt, cmd_rd, cmd_sa, cmd_imm, cmd_target);
          m_ptr   = m_ptr + 8'd1;
          m_rem   = m_rem - 1;
          if (m_rem == 0) begin
            m_acc     = 0;
            m_last    = 1;
            m_done_in = 2;
          end
        end
      end
      if (m_idle && start) begin
        m_err = 0;
        m_ptr = base_addr;
        m_rem = int'(prog_len);
        if (prog_len == 9'd0) m_done_in = 1;
        else                  m_acc = 1;
      end
      e_ready = m_acc;
      e_busy  = m_acc || m_last;
      e_err   = m_err;
    end
  end

  // Writes seen on the IMEM port, for the directed literal checks
  logic [39:0] obs_q [$];

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (model_ok) begin
      check("imem_we",    64'(imem_we),    64'(e_we && !rst));
      check("imem_addr",  64'(imem_addr),  64'(e_addr));
      check("imem_wdata", 64'(imem_wdata), 64'(e_wdata));
      check("cmd_ready",  64'(cmd_ready),  64'(e_ready));
      check("busy",       64'(busy),       64'(e_busy));
      check("done",       64'(done),       64'(e_done));
      check("err",        64'(err),        64'(e_err));
      if (imem_we) obs_q.push_back({imem_addr, imem_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1; base_addr = b; prog_len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] tgt);
    bit got;
    int n;
    cmd_valid = 1'b1; cmd_mnem = m; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_sa = sa;
    cmd_imm = imm; cmd_target = tgt;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      got = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    check("handshake", 64'(got), 64'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 64'(seen), 64'd1);
    tick();
  endtask

  task automatic check_obs(input string name, input int idx, input logic [7:0] a, input logic [31:0] d);
    logic [39:0] v;
    v = (idx < obs_q.size()) ? obs_q[idx] : 40'hXX_XXXXXXXX;
    check(name, 64'(v), 64'({a, d}));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; base_addr = 8'd0; prog_len = 9'd0;
    cmd_mnem = 4'd0; cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_rd = 5'd0; cmd_sa = 5'd0;
    cmd_imm = 16'd0; cmd_target = 26'd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_we",    64'(imem_we),   64'd0);
    check("rst_addr",  64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_done",  64'(done),      64'd0);
    check("rst_err",   64'(err),       64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single ADD at 0x10
    obs_q.delete();
    do_start(8'h10, 9'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    wait_done();
    check("t1_count", 64'(obs_q.size()), 64'd1);
    check_obs("t1_w0", 0, 8'h10, 32'h00221801);

    // Back-to-back ADDI / SLL / J with junk in unused fields
    obs_q.delete();
    do_start(8'h40, 9'd3);
    send(4'd6,  5'd0,  5'd5,  5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF);
    send(4'd5,  5'd9,  5'd2,  5'd4,  5'd3,  16'hFFFF, 26'h3FFFFFF);
    send(4'd14, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'h1234, 26'h0000010);
    wait_done();
    check("t2_count", 64'(obs_q.size()), 64'd3);
    check_obs("t2_w0", 0, 8'h40, 32'h1405FFFF);
    check_obs("t2_w1", 1, 8'h41, 32'h080220C3);
    check_obs("t2_w2", 2, 8'h42, 32'h48000010);

    // Address wrap from 0xFF
    obs_q.delete();
    do_start(8'hFF, 9'd2);
    send(4'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004, 26'h0);
    send(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0000, 26'h0);
    wait_done();
    check_obs("t3_w0", 0, 8'hFF, 32'h3C220004);
    check_obs("t3_w1", 1, 8'h00, 32'h38220000);

    // Illegal command is swallowed and sets the sticky error
    obs_q.delete();
    do_start(8'h30, 9'd2);
    send(4'd15, 5'd7, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h0);
    send(4'd8,  5'd3, 5'd4, 5'd0, 5'd0, 16'h00F0, 26'h0);
    send(4'd1,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0);
    wait_done();
    check("t4_count", 64'(obs_q.size()), 64'd2);
    check_obs("t4_w0", 0, 8'h30, 32'h286400F0);
    check_obs("t4_w1", 1, 8'h31, 32'h04221801);
    repeat (2) tick();
    @(negedge clk);
    check("t4_err_hold", 64'(err), 64'd1);
    tick();

    // Empty program: err clears on start, done two cycles after start
    obs_q.delete();
    do_start(8'h00, 9'd0);
    @(negedge clk);
    check("t5_err_clr", 64'(err),  64'd0);
    check("t5_done_d1", 64'(done), 64'd0);
    @(negedge clk);
    check("t5_done_d2", 64'(done), 64'd1);
    tick();
    check("t5_nowrite", 64'(obs_q.size()), 64'd0);

    // Reset right after a handshake suppresses the staged write
    obs_q.delete();
    do_start(8'h20, 9'd3);
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_we_killed", 64'(imem_we), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 64'(busy),       64'd0);
    check("t6_addr", 64'(imem_addr),  64'd0);
    check("t6_data", 64'(imem_wdata), 64'd0);
    check("t6_nowrite", 64'(obs_q.size()), 64'd0);
    tick();

    // Randomised sessions with gaps, illegal codes and ignored start pulses
    for (int s = 0; s < 30; s++) begin
      int len, legal;
      len = $urandom_range(0, 6);
      do_start(8'($urandom), 9'(len));
      legal = 0;
      while (legal < len) begin
        logic [3:0] m;
        repeat ($urandom_range(0, 2)) tick();
        m = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) begin
          start = 1'b1; base_addr = 8'($urandom); prog_len = 9'($urandom_range(0, 6));
        end
        send(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 26'($urandom));
        start = 1'b0;
        if (m != 4'd15) legal++;
      end
      wait_done();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
